// File: rtl/wb_register_file_if.sv
// Bus between the MEM/WB pipeline register, decode read ports, debug unit
// and the write-back / register-file block.
interface wb_register_file_if #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
);
  logic              i_enable;
  logic [NBITS-1:0]  i_PC4;
  logic [NBITS-1:0]  i_ALU;
  logic [NBITS-1:0]  i_DatoMemoria;
  logic [RNBITS-1:0] i_RegistroDestino;
  logic              i_MemToReg;
  logic              i_RegWrite;
  logic              i_Link;
  logic [RNBITS-1:0] i_RegA;
  logic [RNBITS-1:0] i_RegB;
  logic [RNBITS-1:0] i_DebugAddr;
  logic [NBITS-1:0]  o_DatoA;
  logic [NBITS-1:0]  o_DatoB;
  logic [NBITS-1:0]  o_DatoWB;
  logic [NBITS-1:0]  o_DebugDato;
  logic [31:0]       o_WriteCount;

  modport master (
    output i_enable, i_PC4, i_ALU, i_DatoMemoria, i_RegistroDestino,
           i_MemToReg, i_RegWrite, i_Link, i_RegA, i_RegB, i_DebugAddr,
    input  o_DatoA, o_DatoB, o_DatoWB, o_DebugDato, o_WriteCount
  );

  modport slave (
    input  i_enable, i_PC4, i_ALU, i_DatoMemoria, i_RegistroDestino,
           i_MemToReg, i_RegWrite, i_Link, i_RegA, i_RegB, i_DebugAddr,
    output o_DatoA, o_DatoB, o_DatoWB, o_DebugDato, o_WriteCount
  );
endinterface

// File: rtl/wb_register_file.sv
// MIPS write-back stage: selects the write-back value, commits it to the
// 32-entry register file, serves two bypassed read ports and a debug port.
module wb_register_file #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
) (
  input logic               i_clk,
  input logic               i_reset,
  wb_register_file_if.slave bus
);
  localparam int DEPTH = 1 << RNBITS;

  logic [NBITS-1:0] regs [DEPTH];
  logic [31:0]      write_count;
  logic [NBITS-1:0] dato_wb;
  logic             we;

  // Link has priority over the load path
  assign dato_wb = bus.i_Link     ? bus.i_PC4 :
                   bus.i_MemToReg ? bus.i_DatoMemoria : bus.i_ALU;

  assign we = bus.i_enable & bus.i_RegWrite &
              (bus.i_RegistroDestino != '0) & ~i_reset;

  function automatic logic [NBITS-1:0] read_port(input logic [RNBITS-1:0] idx,
                                                 input logic              bypass);
    if (idx == '0)
      return '0;
    else if (bypass && we && (idx == bus.i_RegistroDestino))
      return dato_wb;
    else
      return regs[idx];
  endfunction

  always_comb begin
    bus.o_DatoA     = read_port(bus.i_RegA, 1'b1);
    bus.o_DatoB     = read_port(bus.i_RegB, 1'b1);
    bus.o_DebugDato = read_port(bus.i_DebugAddr, 1'b0);
  end

  assign bus.o_DatoWB     = dato_wb;
  assign bus.o_WriteCount = write_count;

  // Commit edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      write_count <= '0;
    end else if (we) begin
      regs[bus.i_RegistroDestino] <= dato_wb;
      write_count                 <= write_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: directed vector table, hand sequences for
// counter wrap, then randomized traffic against an array-based model.
module tb_wb_register_file;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_register_file_if #(.NBITS(32), .RNBITS(5)) bus ();
  wb_register_file #(.NBITS(32), .RNBITS(5)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, rw, mtr, link, rs;
    logic [31:0] pc4, alu, mem;
    logic [4:0]  dest, ra, rb, dbg;
    logic [31:0] exp_a, exp_b, exp_wb, exp_dbg, exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                   = v.rs;
    bus.i_enable          = v.en;
    bus.i_RegWrite        = v.rw;
    bus.i_MemToReg        = v.mtr;
    bus.i_Link            = v.link;
    bus.i_PC4             = v.pc4;
    bus.i_ALU             = v.alu;
    bus.i_DatoMemoria     = v.mem;
    bus.i_RegistroDestino = v.dest;
    bus.i_RegA            = v.ra;
    bus.i_RegB            = v.rb;
    bus.i_DebugAddr       = v.dbg;
  endtask

  function automatic vec_t mk(input logic en, rw, mtr, link, rs,
                              input logic [31:0] pc4, alu, mem,
                              input logic [4:0] dest, ra, rb, dbg,
                              input logic [31:0] ea, eb, ewb, edbg, ecnt);
    vec_t v;
    v.en = en; v.rw = rw; v.mtr = mtr; v.link = link; v.rs = rs;
    v.pc4 = pc4; v.alu = alu; v.mem = mem;
    v.dest = dest; v.ra = ra; v.rb = rb; v.dbg = dbg;
    v.exp_a = ea; v.exp_b = eb; v.exp_wb = ewb; v.exp_dbg = edbg; v.exp_cnt = ecnt;
    return v;
  endfunction

  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;
  vec_t        r;
  logic [31:0] wbv, ea, eb, ed;
  logic        wen;

  initial begin
    //            en rw mtr lnk rst  pc4    alu           mem           dst ra  rb  dbg   expA          expB          expWB         expDbg        cnt
    vecs[0]  = mk(1, 1, 0,  0,  0, 32'h0, 32'h1234,     32'h0,        5,  5,  0,  5,  32'h1234,     32'h0,        32'h1234,     32'h0,        0);
    vecs[1]  = mk(1, 0, 0,  0,  0, 32'h0, 32'h0,        32'h0,        0,  5,  5,  5,  32'h1234,     32'h1234,     32'h0,        32'h1234,     1);
    vecs[2]  = mk(1, 1, 0,  0,  0, 32'h0, 32'hFFFFFFFF, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1);
    vecs[3]  = mk(1, 1, 1,  1,  0, 32'h40,32'h1,        32'hDEADBEEF, 31, 31, 31, 0,  32'h40,       32'h40,       32'h40,       32'h0,        1);
    vecs[4]  = mk(1, 1, 1,  0,  0, 32'h0, 32'h0,        32'hDEADBEEF, 7,  31, 7,  31, 32'h40,       32'hDEADBEEF, 32'hDEADBEEF, 32'h40,       2);
    vecs[5]  = mk(0, 1, 0,  0,  0, 32'h0, 32'h55,       32'h0,        9,  9,  7,  7,  32'h0,        32'hDEADBEEF, 32'h55,       32'hDEADBEEF, 3);
    vecs[6]  = mk(1, 0, 0,  0,  0, 32'h0, 32'h0,        32'h0,        0,  9,  0,  9,  32'h0,        32'h0,        32'h0,        32'h0,        3);
    vecs[7]  = mk(1, 1, 0,  0,  1, 32'h0, 32'hA5,       32'h0,        3,  3,  3,  7,  32'h0,        32'h0,        32'hA5,       32'hDEADBEEF, 3);
    vecs[8]  = mk(1, 0, 0,  0,  0, 32'h0, 32'h0,        32'h0,        0,  3,  7,  31, 32'h0,        32'h0,        32'h0,        32'h0,        0);
    vecs[9]  = mk(1, 1, 0,  0,  0, 32'h0, 32'h77,       32'h0,        3,  3,  31, 3,  32'h77,       32'h0,        32'h77,       32'h0,        0);
    vecs[10] = mk(1, 0, 0,  0,  0, 32'h0, 32'h0,        32'h0,        0,  3,  0,  3,  32'h77,       32'h0,        32'h0,        32'h77,       1);
    vecs[11] = mk(1, 1, 0,  0,  0, 32'h0, 32'h11,       32'h0,        3,  3,  3,  3,  32'h11,       32'h11,       32'h11,       32'h77,       1);
    vecs[12] = mk(1, 1, 0,  0,  0, 32'h0, 32'h22,       32'h0,        3,  3,  0,  3,  32'h22,       32'h0,        32'h22,       32'h11,       2);
    vecs[13] = mk(1, 0, 0,  0,  0, 32'h0, 32'h0,        32'h0,        0,  3,  3,  3,  32'h22,       32'h22,       32'h0,        32'h22,       3);

    // Reset, then sweep every index on all three read ports
    drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.i_RegA = 5'(i); bus.i_RegB = 5'(i); bus.i_DebugAddr = 5'(i);
      #1;
      check($sformatf("reset_a[%0d]", i), bus.o_DatoA, 32'h0);
      check($sformatf("reset_b[%0d]", i), bus.o_DatoB, 32'h0);
      check($sformatf("reset_dbg[%0d]", i), bus.o_DebugDato, 32'h0);
    end
    check("reset_count", bus.o_WriteCount, 32'h0);

    // Directed table, inputs applied on the falling edge
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k]);
      #2;
      check($sformatf("vec%0d_a", k),   bus.o_DatoA,      vecs[k].exp_a);
      check($sformatf("vec%0d_b", k),   bus.o_DatoB,      vecs[k].exp_b);
      check($sformatf("vec%0d_wb", k),  bus.o_DatoWB,     vecs[k].exp_wb);
      check($sformatf("vec%0d_dbg", k), bus.o_DebugDato,  vecs[k].exp_dbg);
      check($sformatf("vec%0d_cnt", k), bus.o_WriteCount, vecs[k].exp_cnt);
      @(posedge clk);
      @(negedge clk);
    end

    // Counter wrap from all-ones
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    #1;
    check("wrap_preload", bus.o_WriteCount, 32'hFFFF_FFFF);
    drive(mk(1, 1, 0, 0, 0, 0, 32'hCAFE, 0, 4, 4, 0, 4, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 4, 0, 0, 0, 0, 0));
    #1;
    check("wrap_count", bus.o_WriteCount, 32'h0);
    check("wrap_dbg4", bus.o_DebugDato, 32'hCAFE);

    // Randomized traffic against the array model, starting from reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = '0;
    for (int n = 0; n < 400; n++) begin
      r.rs   = ($urandom_range(0, 49) == 0);
      r.en   = ($urandom_range(0, 4) != 0);
      r.rw   = ($urandom_range(0, 3) != 0);
      r.mtr  = 1'($urandom);
      r.link = ($urandom_range(0, 4) == 0);
      r.pc4  = $urandom; r.alu = $urandom; r.mem = $urandom;
      r.dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r.ra   = ($urandom_range(0, 2) == 0) ? r.dest : 5'($urandom);
      r.rb   = ($urandom_range(0, 2) == 0) ? r.dest : 5'($urandom);
      r.dbg  = ($urandom_range(0, 2) == 0) ? r.dest : 5'($urandom);
      drive(r);
      #2;
      wbv = r.link ? r.pc4 : (r.mtr ? r.mem : r.alu);
      wen = r.en && r.rw && (r.dest != 0) && !r.rs;
      ea  = (r.ra == 0) ? 32'h0 : (wen && r.ra == r.dest) ? wbv : model_regs[r.ra];
      eb  = (r.rb == 0) ? 32'h0 : (wen && r.rb == r.dest) ? wbv : model_regs[r.rb];
      ed  = (r.dbg == 0) ? 32'h0 : model_regs[r.dbg];
      check("rand_a",   bus.o_DatoA,      ea);
      check("rand_b",   bus.o_DatoB,      eb);
      check("rand_wb",  bus.o_DatoWB,     wbv);
      check("rand_dbg", bus.o_DebugDato,  ed);
      check("rand_cnt", bus.o_WriteCount, model_cnt);
      @(posedge clk);
      if (r.rs) begin
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_cnt = '0;
      end else if (wen) begin
        model_regs[r.dest] = wbv;
        model_cnt          = model_cnt + 1;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and general-purpose register file of the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result, memory data or link address), and commits it to a 32 x NBITS register file. It serves the two decode-stage read ports with same-cycle write-through bypass, and provides a debug read port plus a retired-write counter for the debug unit.

## Interface
- NBITS, 32, data width of registers and datapath
- RNBITS, 5, register address width; file depth is 2^RNBITS
- i_clk  input  1  system clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_enable  input  1  write-back enable; low freezes register file and counter (debug step/halt)
- i_PC4  input  NBITS  PC+4 of the instruction in WB
- i_ALU  input  NBITS  ALU result from MEM/WB
- i_DatoMemoria  input  NBITS  load data from MEM/WB
- i_RegistroDestino  input  RNBITS  destination register index
- i_MemToReg  input  1  1 = write memory data, 0 = write ALU result
- i_RegWrite  input  1  write request
- i_Link  input  1  1 = write i_PC4 (JAL/JALR link); overrides i_MemToReg
- i_RegA  input  RNBITS  read port A index (rs)
- i_RegB  input  RNBITS  read port B index (rt)
- i_DebugAddr  input  RNBITS  debug read index
- o_DatoA  output  NBITS  read port A data
- o_DatoB  output  NBITS  read port B data
- o_DatoWB  output  NBITS  selected write-back value (combinational, for forwarding unit)
- o_DebugDato  output  NBITS  debug read data
- o_WriteCount  output  32  count of committed register writes

## Operation
- Write-back mux: o_DatoWB = i_Link ? i_PC4 : (i_MemToReg ? i_DatoMemoria : i_ALU). Pure combinational, valid regardless of i_RegWrite/i_enable.
- Commit condition: we = i_enable & i_RegWrite & (i_RegistroDestino != 0) & ~i_reset.
- On rising edge with we: reg[i_RegistroDestino] <= o_DatoWB; o_WriteCount <= o_WriteCount + 1 (wraps 0xFFFFFFFF -> 0).
- Register 0: always reads 0 on all three read ports; writes to it are discarded and not counted.
- Read ports A/B: combinational. If we is asserted and index equals i_RegistroDestino, return o_DatoWB (write-through bypass); otherwise stored value.
- Debug port: combinational, returns stored value only (no bypass); reg 0 reads 0.
- i_enable low: no writes, counter holds; read ports and bypass still operate but bypass is inactive (we = 0).

## Timing
- Reset: on rising edge with i_reset = 1, all registers and o_WriteCount cleared to 0; o_DatoA/o_DatoB/o_DebugDato read 0 for every index from the next cycle. Reset takes priority over a simultaneous write (write lost, not counted).
- Write latency: value visible on stored reads (debug port) the cycle after the commit edge; visible on A/B in the same cycle via bypass.
- MEM/WB register updates on falling edge; inputs are stable a half cycle before the rising commit edge.
- Both read ports addressing the written register simultaneously both receive bypassed data.
- Back-to-back writes to the same register: last write wins; counter increments once per cycle.
- Reset asserted mid-stream for one cycle: state cleared, subsequent writes proceed normally from count 0.

## Test plan
- Reset then read all 32 indices on A, B, debug -> all 0; o_WriteCount = 0.
- RegWrite=1, MemToReg=0, Link=0, ALU=0x0000_1234, dest=5, RegA=5 -> o_DatoA = 0x1234 same cycle (bypass); next cycle debug read 5 = 0x1234, count = 1.
- dest=0, RegWrite=1, ALU=0xFFFF_FFFF -> reg 0 reads 0 on all ports, count unchanged.
- Link=1, MemToReg=1, PC4=0x0000_0040, dest=31 -> reg 31 = 0x40 (link overrides memory); MemToReg=1, Link=0, DatoMemoria=0xDEAD_BEEF, dest=7 -> reg 7 = 0xDEADBEEF.
- i_enable=0 with valid write to reg 9 = 0x55 -> reg 9 unchanged, count unchanged, o_DatoA (RegA=9) shows stored value, not 0x55.
- Write reg 3 = 0xA5 and assert i_reset same edge -> reg 3 = 0, count = 0; preload count to 0xFFFF_FFFF via forced state, one write -> count = 0.
